pipeline_stall_ctrl: RTL and testbench

//  Central stall/flush/redirect scheduler for the 5-stage pipeline.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 21 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush/redirect scheduler:
// FSM states, trap cause codes and the trap vector addresses they select.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  localparam logic [1:0]  TRAP_CAUSE_NONE = 2'b00;
  localparam logic [1:0]  TRAP_CAUSE_IRQ  = 2'b01;
  localparam logic [1:0]  TRAP_CAUSE_EXC  = 2'b10;

  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  // Wide enough for the largest legal drain length (15).
  localparam int DRAIN_W = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                 count <= '0;
    else if (clr)                 count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush/trap-redirect scheduler for the 5-stage pipeline, with
// stall/flush performance counters and a UART-wait watchdog.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int UART_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             ld_use,
  input  logic             j_flush,
  input  logic             br_taken,
  input  logic             exc_req,
  input  logic             irq,
  input  logic             kernel_mode,
  input  logic             uart_wait,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             trap_take,
  output logic [1:0]       trap_cause,
  output logic             uart_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                 WAIT_W     = $clog2(UART_TIMEOUT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);

  state_e             state, next_state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [1:0]         cause_q, enter_cause;
  logic               enter_drain;
  logic [WAIT_W-1:0]  wait_cnt;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    trap_take   = 1'b0;
    trap_cause  = TRAP_CAUSE_NONE;
    enter_drain = 1'b0;
    enter_cause = TRAP_CAUSE_NONE;

    if (!reset_b) begin
      // Pipeline registers are held cleared for as long as reset is low.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (!uart_wait) begin
      unique case (state)
        ST_RUN: begin
          if (br_taken) begin
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (exc_req || (irq && !kernel_mode)) begin
            // Entry cycle issues the first bubble; exception outranks irq.
            enter_drain = 1'b1;
            enter_cause = exc_req ? TRAP_CAUSE_EXC : TRAP_CAUSE_IRQ;
            id_ex_flush = 1'b1;
            next_state  = (DRAIN_CYCLES <= 1) ? ST_TRAP : ST_DRAIN;
          end else if (j_flush) begin
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
          end else if (ld_use) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        ST_DRAIN: begin
          id_ex_flush = 1'b1;
          if (drain_cnt + 1'b1 == DRAIN_LAST) next_state = ST_TRAP;
        end
        ST_TRAP: begin
          trap_take   = 1'b1;
          trap_cause  = cause_q;
          pc_write    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          next_state  = ST_RUN;
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  // NOTE: only control state is reset here; there is no storage array needing a reset sweep.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      cause_q   <= TRAP_CAUSE_NONE;
    end else if (!uart_wait) begin
      state <= next_state;
      if (enter_drain) begin
        drain_cnt <= DRAIN_W'(1);
        cause_q   <= enter_cause;
      end else if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  // Watchdog: counts consecutive wait cycles, flags once UART_TIMEOUT of them have elapsed.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wait_cnt     <= '0;
      uart_timeout <= 1'b0;
    end else if (!uart_wait) begin
      wait_cnt <= '0;
    end else begin
      if (wait_cnt != WAIT_W'(UART_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WAIT_W'(UART_TIMEOUT - 1)) uart_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .inc     (!pc_write && !uart_wait),
    .clr     (1'b0),
    .count   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .inc     (if_id_flush),
    .clr     (1'b0),
    .count   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: priority cases, drain/trap sequencing,
// uart_wait freeze, watchdog and reset abort, with hand-computed expectations.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        ld_use, j_flush, br_taken, exc_req, irq, kernel_mode, uart_wait;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, trap_take;
  logic [1:0]  trap_cause;
  logic        uart_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Control vector: {pc_write, if_id_write, if_id_flush, id_ex_flush, trap_take, trap_cause}
  localparam logic [6:0] CTL_RESET = 7'b0011_0_00;
  localparam logic [6:0] CTL_IDLE  = 7'b1100_0_00;
  localparam logic [6:0] CTL_BUBB  = 7'b0001_0_00;
  localparam logic [6:0] CTL_BR    = 7'b1011_0_00;
  localparam logic [6:0] CTL_FRZ   = 7'b0000_0_00;
  localparam logic [6:0] CTL_T_IRQ = 7'b1011_1_01;
  localparam logic [6:0] CTL_T_EXC = 7'b1011_1_10;

  pipeline_stall_ctrl #(
    .DRAIN_CYCLES (2),
    .CNT_W        (16),
    .UART_TIMEOUT (1000)
  ) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .ld_use       (ld_use),
    .j_flush      (j_flush),
    .br_taken     (br_taken),
    .exc_req      (exc_req),
    .irq          (irq),
    .kernel_mode  (kernel_mode),
    .uart_wait    (uart_wait),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .trap_take    (trap_take),
    .trap_cause   (trap_cause),
    .uart_timeout (uart_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, trap_take, trap_cause},
        {25'd0, exp});
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset_b = 1'b0;
    {ld_use, j_flush, br_taken, exc_req, irq, kernel_mode, uart_wait} = '0;
    #2;
    chk_ctl("reset_ctl", CTL_RESET);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset_timeout", 32'(uart_timeout), 32'd0);

    repeat (2) @(posedge clk);
    #1 reset_b = 1'b1;
    #1 chk_ctl("idle_after_reset", CTL_IDLE);

    // Load-use: one-cycle stall.
    cyc(); ld_use = 1'b1;
    #1 chk_ctl("ld_use_stall", CTL_BUBB);
    cyc(); ld_use = 1'b0;
    #1 chk_ctl("ld_use_release", CTL_IDLE);
    chk("stall_cnt_after_ld_use", 32'(stall_cnt), 32'd1);

    // Branch outranks jump and load-use.
    br_taken = 1'b1; j_flush = 1'b1; ld_use = 1'b1;
    #1 chk_ctl("br_priority", CTL_BR);
    cyc(); {br_taken, j_flush, ld_use} = '0;
    #1 chk("stall_cnt_after_br", 32'(stall_cnt), 32'd1);
    chk("flush_cnt_after_br", 32'(flush_cnt), 32'd1);

    // Jump alone: pc_write plus IF_ID flush only.
    j_flush = 1'b1;
    #1 chk_ctl("jump_flush", 7'b1010_0_00);
    cyc(); j_flush = 1'b0;

    // IRQ trap; dropping irq mid-drain must not cancel it.
    irq = 1'b1; kernel_mode = 1'b0;
    #1 chk_ctl("irq_entry_bubble", CTL_BUBB);
    cyc(); irq = 1'b0;
    #1 chk_ctl("irq_drain_bubble", CTL_BUBB);
    cyc();
    #1 chk_ctl("irq_trap", CTL_T_IRQ);
    cyc();
    #1 chk_ctl("irq_back_to_run", CTL_IDLE);
    chk("stall_cnt_after_irq", 32'(stall_cnt), 32'd3);
    chk("flush_cnt_after_irq", 32'(flush_cnt), 32'd3);

    // Kernel mode masks irq.
    irq = 1'b1; kernel_mode = 1'b1;
    #1 chk_ctl("irq_masked_kernel", CTL_IDLE);

    // irq + exc_req together: exception first, pending irq second.
    cyc(); exc_req = 1'b1; kernel_mode = 1'b0;
    #1 chk_ctl("dual_entry_bubble", CTL_BUBB);
    cyc(); exc_req = 1'b0;
    #1 chk_ctl("dual_drain_bubble", CTL_BUBB);
    cyc();
    #1 chk_ctl("dual_trap_exc", CTL_T_EXC);
    cyc();
    #1 chk_ctl("pending_irq_entry", CTL_BUBB);
    cyc();
    #1 chk_ctl("pending_irq_drain", CTL_BUBB);
    cyc(); irq = 1'b0;
    #1 chk_ctl("pending_irq_trap", CTL_T_IRQ);
    cyc();
    #1 chk_ctl("dual_back_to_run", CTL_IDLE);
    chk("stall_cnt_after_dual", 32'(stall_cnt), 32'd7);
    chk("flush_cnt_after_dual", 32'(flush_cnt), 32'd5);

    // uart_wait for 3 cycles mid-drain freezes everything and delays the trap.
    exc_req = 1'b1;
    #1 chk_ctl("uw_entry_bubble", CTL_BUBB);
    cyc(); exc_req = 1'b0; uart_wait = 1'b1;
    #1 chk_ctl("uw_frozen_1", CTL_FRZ);
    cyc();
    #1 chk_ctl("uw_frozen_2", CTL_FRZ);
    cyc();
    #1 chk_ctl("uw_frozen_3", CTL_FRZ);
    cyc(); uart_wait = 1'b0;
    #1 chk_ctl("uw_resume_drain", CTL_BUBB);
    cyc();
    #1 chk_ctl("uw_delayed_trap", CTL_T_EXC);
    cyc();
    #1 chk_ctl("uw_back_to_run", CTL_IDLE);
    chk("stall_cnt_after_uw", 32'(stall_cnt), 32'd9);
    chk("flush_cnt_after_uw", 32'(flush_cnt), 32'd6);
    chk("timeout_short_wait", 32'(uart_timeout), 32'd0);

    // Watchdog: 999 wait cycles not enough, the 1000th sets the sticky flag.
    uart_wait = 1'b1;
    repeat (999) cyc();
    chk("timeout_999", 32'(uart_timeout), 32'd0);
    cyc();
    chk("timeout_1000", 32'(uart_timeout), 32'd1);
    chk("stall_cnt_excl_wait", 32'(stall_cnt), 32'd9);
    uart_wait = 1'b0;
    cyc();
    chk("timeout_sticky", 32'(uart_timeout), 32'd1);

    // Reset mid-drain aborts the trap.
    exc_req = 1'b1;
    cyc(); exc_req = 1'b0;
    #1 chk_ctl("rst_pre_drain", CTL_BUBB);
    reset_b = 1'b0;
    #1 chk_ctl("rst_mid_drain", CTL_RESET);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_timeout", 32'(uart_timeout), 32'd0);
    cyc();
    chk_ctl("rst_held_no_trap", CTL_RESET);
    cyc(); reset_b = 1'b1;
    #1 chk_ctl("rst_release_idle", CTL_IDLE);
    cyc();
    #1 chk_ctl("rst_no_late_trap", CTL_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
